// File: rtl/count_enable_gen_pkg.sv
// count_enable_gen_pkg
//   Shared definitions for the count-enable generator. It holds the FSM state
//   encoding and the default parameters that the top level and the button
//   conditioner both use.
package count_enable_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam int unsigned DIV_W_DEFAULT      = 8;
    localparam int unsigned DEB_CYCLES_DEFAULT = 4;
    localparam int unsigned DEB_W_DEFAULT      = 3;

endpackage

// File: rtl/count_enable_gen_btn_debounce.sv
// btn_debounce
//   Conditions one raw push-button. The path is a 2-FF synchronizer, then a
//   debouncer, then a rising-edge detector. The debounced level changes only
//   after the synchronized input has disagreed with it for DEB_CYCLES
//   consecutive clocks. Shorter pulses are ignored.
// Ports
//   clk     in  1  clock; all logic on posedge
//   rst     in  1  synchronous active-high reset
//   btn_raw in  1  asynchronous raw button level
//   rise    out 1  one-cycle pulse on a debounced 0->1 transition
module btn_debounce
    import count_enable_gen_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic rise
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = '0;
        // Any sample that agrees with the debounced level restarts the count.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise = db_q & ~db_dly_q;

endmodule

// File: rtl/count_enable_gen.sv
// count_enable_gen
//   Enable source for the downstream 2-bit counter. The run button toggles
//   between IDLE and RUN. In RUN, a programmable prescaler emits a 1-cycle
//   enable every div clocks; a div of 0 behaves as 1. In IDLE, each step
//   press yields exactly one enable pulse.
// Ports
//   clk      in  1      clock; all logic on posedge
//   rst      in  1      synchronous active-high reset
//   run_btn  in  1      raw run/stop toggle button
//   step_btn in  1      raw single-step button (honoured in IDLE only)
//   div      in  DIV_W  prescale divisor, sampled every cycle
//   en       out 1      registered enable pulse
//   running  out 1      registered, high while in RUN
module count_enable_gen
    import count_enable_gen_pkg::*;
#(
    parameter int unsigned DIV_W      = DIV_W_DEFAULT,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div,
    output logic             en,
    output logic             running
);

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic             running_q, running_d;
    logic [DIV_W-1:0] pc_q, pc_d;
    logic [DIV_W-1:0] div_last;
    logic             run_rise, step_rise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_run_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (run_btn),
        .rise    (run_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_step_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (step_btn),
        .rise    (step_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            running_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            running_q <= running_d;
            pc_q      <= pc_d;
        end
    end

    // A run edge takes priority over a step edge, so a simultaneous press
    // enters RUN and the step is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_rise)       state_d = ST_RUN;
                else if (step_rise) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (run_rise) state_d = ST_IDLE;
            end
            ST_STEP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Terminal count is div-1, with div==0 folded onto 1. The >= compare
    // lets a divisor shrunk below the current count fire once and wrap.
    always_comb begin
        div_last  = (div == '0) ? '0 : div - 1'b1;
        en_d      = 1'b0;
        pc_d      = pc_q;
        case (state_q)
            ST_IDLE: pc_d = '0;
            ST_RUN: begin
                if (run_rise) begin
                    pc_d = '0;
                end else if (pc_q >= div_last) begin
                    pc_d = '0;
                    en_d = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_STEP: begin
                en_d = 1'b1;
                pc_d = '0;
            end
            default: pc_d = '0;
        endcase
        running_d = (state_d == ST_RUN);
    end

    assign en      = en_q;
    assign running = running_q;

endmodule

// File: tb/tb_count_enable_gen.sv
module tb_count_enable_gen;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       run_btn  = 1'b0;
    logic       step_btn = 1'b0;
    logic [7:0] div      = 8'd4;
    logic       en;
    logic       running;

    // Downstream 2-bit counter, with its own reset.
    logic       ctr_rst = 1'b1;
    logic [1:0] c = 2'd0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int en_count      = 0;
    int last_en_cyc   = 0;
    int last_gap      = 0;
    int run_start_cyc = 0;
    bit prev_running  = 1'b0;

    // Behavioural model state: index 0 = run button, 1 = step button.
    bit [1:0] m_s1, m_s2, m_db, m_dbp;
    bit [3:0] m_sh [2];
    bit       m_running, m_step, m_en;
    int       m_pc;

    always #5 clk = ~clk;

    count_enable_gen #(.DIV_W(8), .DEB_CYCLES(4), .DEB_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .div      (div),
        .en       (en),
        .running  (running)
    );

    always @(posedge clk) begin
        if (ctr_rst) c <= 2'd0;
        else if (en) c <= c + 2'd1;
    end

    // Model: a button level is accepted once the last four synchronized
    // samples all disagree with the accepted level. Synchronized = raw two
    // clocks late. The mode rules follow the run/step/prescale behaviour.
    always @(posedge clk) begin : model
        bit [1:0] raw;
        bit       rr, sr, nen;
        int       de;
        cyc++;
        raw = {step_btn, run_btn};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
            m_sh[0] = '0; m_sh[1] = '0;
            m_running = 1'b0; m_step = 1'b0; m_en = 1'b0; m_pc = 0;
        end else begin
            rr  = m_db[0] & ~m_dbp[0];
            sr  = m_db[1] & ~m_dbp[1];
            nen = 1'b0;
            de  = (div == 8'd0) ? 1 : int'(div);
            if (m_step) begin
                nen    = 1'b1;
                m_step = 1'b0;
            end else if (m_running) begin
                if (rr) begin
                    m_running = 1'b0;
                    m_pc      = 0;
                end else if (m_pc >= de - 1) begin
                    m_pc = 0;
                    nen  = 1'b1;
                end else begin
                    m_pc = m_pc + 1;
                end
            end else if (rr) begin
                m_running = 1'b1;
                m_pc      = 0;
            end else if (sr) begin
                m_step = 1'b1;
            end
            m_en = nen;
            for (int b = 0; b < 2; b++) begin
                m_dbp[b] = m_db[b];
                m_sh[b]  = {m_sh[b][2:0], m_s2[b]};
                if (m_sh[b] == {4{~m_db[b]}}) m_db[b] = ~m_db[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d (cyc %0d)", name, got, lo, hi, cyc);
        end
    endtask

    // One clock: compare DUT against the model on the falling edge, then
    // return 1 time unit after the next rising edge, ready for new drive.
    task automatic step();
        @(negedge clk);
        chk("en_vs_model", int'(en), int'(m_en));
        chk("running_vs_model", int'(running), int'(m_running));
        if (en) begin
            en_count++;
            last_gap    = cyc - last_en_cyc;
            last_en_cyc = cyc;
        end
        if (running && !prev_running) run_start_cyc = cyc;
        prev_running = running;
        @(posedge clk);
        #1;
    endtask

    task automatic press_run(output int lat);
        bit start;
        start   = running;
        lat     = -1;
        run_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (lat < 0 && running != start) lat = i;
        end
        run_btn = 1'b0;
        repeat (10) step();
        chk_range("run_toggle_latency", lat, 6, 8);
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        repeat (10) step();
        step_btn = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        int lat;
        int base;
        int guard;

        // 1: reset held with buttons toggling
        for (int i = 0; i < 3; i++) begin
            run_btn  = ~run_btn;
            step_btn = ~step_btn;
            step();
            chk("reset_en", int'(en), 0);
            chk("reset_running", int'(running), 0);
        end
        rst      = 1'b0;
        ctr_rst  = 1'b0;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        repeat (20) step();
        chk("no_pulse_after_reset", en_count, 0);
        chk("idle_after_reset", int'(running), 0);

        // 2: run with div=4, counter wraps 0,1,2,3,0
        div = 8'd4;
        press_run(lat);
        chk("running_after_run", int'(running), 1);
        guard = 0;
        while (cyc < run_start_cyc + 16 && guard < 40) begin
            step();
            guard++;
        end
        chk("c_after_3_pulses", int'(c), 3);
        step();
        chk("c_wrap", int'(c), 0);
        chk("run_period_div4", last_gap, 4);
        press_run(lat);
        chk("stopped", int'(running), 0);

        // 3: step presses in IDLE, then step ignored in RUN
        ctr_rst = 1'b1;
        step();
        ctr_rst = 1'b0;
        base = en_count;
        repeat (3) press_step();
        chk("three_step_pulses", en_count - base, 3);
        chk("c_after_steps", int'(c), 3);
        div = 8'd200;
        press_run(lat);
        base = en_count;
        press_step();
        chk("step_ignored_in_run", en_count - base, 0);
        chk("still_running", int'(running), 1);
        press_run(lat);

        // 4: glitch rejection and bounce
        run_btn = 1'b1;
        repeat (2) step();
        run_btn = 1'b0;
        repeat (15) step();
        chk("glitch_ignored", int'(running), 0);
        run_btn = 1'b1; step();
        run_btn = 1'b0; step();
        run_btn = 1'b1;
        repeat (10) step();
        run_btn = 1'b0;
        repeat (12) step();
        chk("bounce_one_toggle", int'(running), 1);
        press_run(lat);

        // 5: div=0 acts as 1, then mid-run divisor decrease
        div = 8'd0;
        press_run(lat);
        base = en_count;
        repeat (10) step();
        chk("div0_every_cycle", en_count - base, 10);
        chk("div0_gap", last_gap, 1);
        press_run(lat);
        div = 8'd200;
        press_run(lat);
        guard = 0;
        while (cyc < run_start_cyc + 50 && guard < 80) begin
            step();
            guard++;
        end
        chk("pc_reached_50", cyc - run_start_cyc, 50);
        div = 8'd3;
        step();
        chk("div_drop_fires_next", int'(en), 1);
        repeat (6) step();
        chk("div3_period", last_gap, 3);
        press_run(lat);

        // 6: simultaneous run+step in IDLE, then reset mid-run
        div      = 8'd200;
        base     = en_count;
        run_btn  = 1'b1;
        step_btn = 1'b1;
        repeat (12) step();
        run_btn  = 1'b0;
        step_btn = 1'b0;
        repeat (10) step();
        chk("simul_enters_run", int'(running), 1);
        chk("simul_no_step_pulse", en_count - base, 0);
        div = 8'd1;
        repeat (3) step();
        chk("div1_en_high", int'(en), 1);
        rst = 1'b1;
        step();
        chk("rst_midrun_en", int'(en), 0);
        chk("rst_midrun_running", int'(running), 0);
        rst = 1'b0;
        repeat (5) step();
        chk("idle_after_midrun_rst", int'(en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
